// File: rtl/cmp_stats.sv
// cmp_stats -- accumulates comparator statistics over a fixed-length window.
//
// Counts the accepted comparator results per category (a>b, a==b, a<b) over
// N_SAMPLES accepted samples. It also tracks the longest run of consecutive
// a==b results. Results are held until the next start.
//
// Optional feature macro: CMP_STATS_ERR_CHECK_EN
//   defined   : non-one-hot cmp codes are counted in err_cnt only
//   undefined : err_cnt is tied to 0 and cmp is priority-decoded gt > eq > lt
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a new window (honoured in IDLE and DONE)
//   in_valid   in   qualifies cmp as a sample to accept
//   cmp[2:0]   in   comparator result: [2]=a>b, [1]=a==b, [0]=a<b
//   busy       out  window in progress
//   done       out  completed-window results are held
//   gt_cnt     out  accepted a>b count
//   eq_cnt     out  accepted a==b count
//   lt_cnt     out  accepted a<b count
//   err_cnt    out  accepted illegal-code count
//   eq_run_max out  longest run of consecutive accepted a==b samples
//
// state | meaning
// IDLE  | waiting for start, outputs at reset values
// RUN   | accepting samples until N_SAMPLES have been taken
// DONE  | window complete, results frozen until start

module cmp_stats #(
  parameter int N_SAMPLES = 16,
  parameter int CW        = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [2:0]    cmp,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] gt_cnt,
  output logic [CW-1:0] eq_cnt,
  output logic [CW-1:0] lt_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] eq_run_max
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic          clear;
  logic          accept;
  logic [CW-1:0] remain;
  logic [CW-1:0] cur_run;
  logic [CW-1:0] run_inc;
  logic          is_gt;
  logic          is_eq;
  logic          is_lt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

`ifdef CMP_STATS_ERR_CHECK_EN
  logic is_err;

  assign is_gt  = (cmp == 3'b100);
  assign is_eq  = (cmp == 3'b010);
  assign is_lt  = (cmp == 3'b001);
  assign is_err = !(is_gt || is_eq || is_lt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clear) begin
      err_cnt <= '0;
    end else if (accept && is_err) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end
`else
  // Priority decode; an all-zero code matches nothing and only breaks the eq run.
  assign is_gt   = cmp[2];
  assign is_eq   = !cmp[2] && cmp[1];
  assign is_lt   = !cmp[2] && !cmp[1] && cmp[0];
  assign err_cnt = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (remain == CW'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          clear      = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign run_inc = sat_inc(cur_run);

  // remain is a down-counter of samples still to accept; terminal count is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain     <= '0;
      cur_run    <= '0;
      gt_cnt     <= '0;
      eq_cnt     <= '0;
      lt_cnt     <= '0;
      eq_run_max <= '0;
    end else if (clear) begin
      remain     <= CW'(N_SAMPLES);
      cur_run    <= '0;
      gt_cnt     <= '0;
      eq_cnt     <= '0;
      lt_cnt     <= '0;
      eq_run_max <= '0;
    end else if (accept) begin
      remain <= remain - CW'(1);
      if (is_gt) gt_cnt <= sat_inc(gt_cnt);
      if (is_lt) lt_cnt <= sat_inc(lt_cnt);
      if (is_eq) begin
        eq_cnt     <= sat_inc(eq_cnt);
        cur_run    <= run_inc;
        eq_run_max <= (run_inc > eq_run_max) ? run_inc : eq_run_max;
      end else begin
        cur_run <= '0;
      end
    end
  end

endmodule
